// File: rtl/ut88_dma_loader.sv
// ut88_dma_loader: bus-mastering loader that takes the UT88 bus from the TV80
// with BUSRQ/BUSAK and streams host bytes into memory with sequential writes.
// Every output is decoded from the state register or a register, so nothing
// on the input side reaches an output within the same cycle.
module ut88_dma_loader #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_stb,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_len,
  output logic        cmd_busy,
  input  logic        data_stb,
  input  logic [7:0]  data_in,
  output logic        data_ready,
  output logic        busrq,
  input  logic        busak,
  output logic [15:0] ma,
  output logic [7:0]  mdo,
  output logic        mmreq,
  output logic        mwr,
  input  logic        mwait,
  output logic        done,
  output logic        err
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIMIT = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DATA,
    S_WRITE,
    S_RELEASE
  } state_t;

  state_t        state, state_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   count_q, count_d;
  logic [TW-1:0] tcount_q, tcount_d;
  logic [7:0]    byte_q, byte_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  // State and datapath registers; reset clears everything so the bus is let go at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      count_q  <= '0;
      tcount_q <= '0;
      byte_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      tcount_q <= tcount_d;
      byte_q   <= byte_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: command accept, grant wait with timeout, byte handshake,
  // wait-stated write, and bus release; a lost grant aborts to IDLE with ERR
  always_comb begin
    state_d  = state;
    addr_d   = addr_q;
    count_d  = count_q;
    tcount_d = tcount_q;
    byte_d   = byte_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_stb) begin
          addr_d  = cmd_addr;
          count_d = cmd_len;
          if (cmd_len == 16'd0) begin
            done_d = 1'b1;
          end else begin
            state_d  = S_REQ;
            tcount_d = '0;
          end
        end
      end
      S_REQ: begin
        if (busak) begin
          state_d = S_DATA;
        end else if ((TIMEOUT != 0) && (tcount_q == TLIMIT)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tcount_d = tcount_q + 1'b1;
        end
      end
      S_DATA: begin
        if (!busak) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (data_stb) begin
          byte_d  = data_in;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!busak) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (!mwait) begin
          addr_d  = addr_q + 16'd1;
          count_d = count_q - 16'd1;
          state_d = (count_q == 16'd1) ? S_RELEASE : S_DATA;
        end
      end
      S_RELEASE: begin
        if (!busak) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the state register and the address/byte registers only
  always_comb begin
    cmd_busy   = (state != S_IDLE);
    data_ready = (state == S_DATA);
    busrq      = (state == S_REQ) || (state == S_DATA) || (state == S_WRITE);
    mmreq      = (state == S_WRITE);
    mwr        = (state == S_WRITE);
    ma         = (state == S_WRITE) ? addr_q : 16'h0000;
    mdo        = (state == S_WRITE) ? byte_q : 8'h00;
    done       = done_q;
    err        = err_q;
  end

endmodule
